// File: rtl/bot_event_snap_pkg.sv
// Shared encodings for the RojoBot event snapshot block: FSM states,
// register window offsets and control register bit positions.
package bot_event_snap_pkg;

  // State encoding is visible to firmware through the status register.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PEND = 2'd1,
    ST_SERV = 2'd2
  } snap_state_e;

  // Register window offsets relative to PORT_BASE.
  localparam logic [2:0] OFF_LOCX  = 3'd0;
  localparam logic [2:0] OFF_LOCY  = 3'd1;
  localparam logic [2:0] OFF_SENS  = 3'd2;
  localparam logic [2:0] OFF_INFO  = 3'd3;
  localparam logic [2:0] OFF_STAT  = 3'd4;
  localparam logic [2:0] OFF_OVCNT = 3'd5;
  localparam logic [2:0] OFF_TOCNT = 3'd6;

  // Control register (write to OFF_STAT) bit positions.
  localparam int unsigned CTL_RELEASE = 0;
  localparam int unsigned CTL_ENABLE  = 1;
  localparam int unsigned CTL_CLRCNT  = 2;

endpackage

// File: rtl/bot_event_snap_sat_counter8.sv
// 8-bit event counter that sticks at 8'hFF; clear has priority over increment.
module sat_counter8 (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  input  logic       clr,
  output logic [7:0] count
);

  // Count register: clear wins, otherwise increment until saturated.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= 8'h00;
    end else if (clr) begin
      count <= 8'h00;
    end else if (inc && (count != 8'hFF)) begin
      count <= count + 8'd1;
    end
  end

endmodule

// File: rtl/bot_event_snap.sv
// Captures a coherent RojoBot register snapshot on each update event, raises
// the KCPSM6 interrupt, holds the snapshot until firmware releases it, and
// counts dropped events (overruns) and unacknowledged interrupts (timeouts).
module bot_event_snap
  import bot_event_snap_pkg::*;
#(
  parameter logic [7:0]  PORT_BASE   = 8'h20,
  parameter int unsigned ACK_TIMEOUT = 1000,
  parameter logic        EN_RESET    = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       upd_sysregs,
  input  logic [7:0] locx,
  input  logic [7:0] locy,
  input  logic [7:0] sensors,
  input  logic [7:0] botinfo,
  input  logic [7:0] port_id,
  input  logic [7:0] out_port,
  input  logic       write_strobe,
  input  logic       read_strobe,
  input  logic       interrupt_ack,
  output logic       interrupt,
  output logic [7:0] rd_data,
  output logic       snap_busy
);

  localparam int unsigned TW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(ACK_TIMEOUT - 1);

  snap_state_e   state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          upd_q;
  logic          enable_q;
  logic [7:0]    locx_q, locy_q, sens_q, info_q;
  logic [7:0]    rd_data_q, rd_data_d;
  logic [7:0]    ovr_cnt, to_cnt;
  logic          ev, capture, ovr_inc, to_inc;
  logic [7:0]    offset;
  logic          win_hit, ctrl_wr, rel_req, clr_cnt;
  logic          unused_inputs;

  // Reads have no side effects, so the strobe and the upper control bits are unused.
  assign unused_inputs = ^{read_strobe, out_port[7:3]};

  assign ev      = upd_sysregs & ~upd_q;
  assign offset  = port_id - PORT_BASE;
  assign win_hit = (offset[7:3] == 5'b0);
  assign ctrl_wr = write_strobe & win_hit & (offset[2:0] == OFF_STAT);
  assign rel_req = ctrl_wr & out_port[CTL_RELEASE];
  assign clr_cnt = ctrl_wr & out_port[CTL_CLRCNT];

  // Next-state logic: capture, ack/timeout handling and overrun detection.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    capture = 1'b0;
    ovr_inc = 1'b0;
    to_inc  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (ev && enable_q) begin
          capture = 1'b1;
          timer_d = '0;
          state_d = ST_PEND;
        end
      end
      ST_PEND: begin
        if (ev) ovr_inc = 1'b1;
        // Ack has priority over expiry in the same cycle.
        if (interrupt_ack) begin
          state_d = ST_SERV;
        end else if (timer_q == TIMER_LAST) begin
          to_inc  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      ST_SERV: begin
        // A release in the same cycle as an event lets the event start a new capture.
        if (rel_req) begin
          if (ev && enable_q) begin
            capture = 1'b1;
            timer_d = '0;
            state_d = ST_PEND;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (ev) begin
          ovr_inc = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, timer, edge-detect and enable registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      timer_q  <= '0;
      upd_q    <= 1'b0;
      enable_q <= EN_RESET;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      upd_q   <= upd_sysregs;
      if (ctrl_wr) enable_q <= out_port[CTL_ENABLE];
    end
  end

  // Snapshot registers, loaded only on an accepted event.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      locx_q <= 8'h00;
      locy_q <= 8'h00;
      sens_q <= 8'h00;
      info_q <= 8'h00;
    end else if (capture) begin
      locx_q <= locx;
      locy_q <= locy;
      sens_q <= sensors;
      info_q <= botinfo;
    end
  end

  sat_counter8 u_ovr_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (ovr_inc),
    .clr   (clr_cnt),
    .count (ovr_cnt)
  );

  sat_counter8 u_to_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (to_inc),
    .clr   (clr_cnt),
    .count (to_cnt)
  );

  // Read mux for the register window; anything outside it reads zero.
  always_comb begin
    rd_data_d = 8'h00;
    if (win_hit) begin
      case (offset[2:0])
        OFF_LOCX:  rd_data_d = locx_q;
        OFF_LOCY:  rd_data_d = locy_q;
        OFF_SENS:  rd_data_d = sens_q;
        OFF_INFO:  rd_data_d = info_q;
        OFF_STAT:  rd_data_d = {5'b0, state_q, enable_q};
        OFF_OVCNT: rd_data_d = ovr_cnt;
        OFF_TOCNT: rd_data_d = to_cnt;
        default:   rd_data_d = 8'h00;
      endcase
    end
  end

  // Registered read data, updated every cycle regardless of read_strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rd_data_q <= 8'h00;
    else     rd_data_q <= rd_data_d;
  end

  // Interrupt follows PEND directly so reset removes it without waiting for a clock.
  assign interrupt = (state_q == ST_PEND);
  assign snap_busy = (state_q == ST_PEND) || (state_q == ST_SERV);
  assign rd_data   = rd_data_q;

endmodule

// File: tb/tb_bot_event_snap.sv
// Directed self-checking bench for bot_event_snap.
module tb_bot_event_snap;

  logic       clk = 1'b0;
  logic       rst;
  logic       upd_sysregs;
  logic [7:0] locx, locy, sensors, botinfo;
  logic [7:0] port_id, out_port;
  logic       write_strobe, read_strobe, interrupt_ack;
  logic       interrupt;
  logic [7:0] rd_data;
  logic       snap_busy;

  int n_checks = 0;
  int n_errors = 0;

  bot_event_snap #(
    .PORT_BASE   (8'h20),
    .ACK_TIMEOUT (1000),
    .EN_RESET    (1'b1)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .upd_sysregs   (upd_sysregs),
    .locx          (locx),
    .locy          (locy),
    .sensors       (sensors),
    .botinfo       (botinfo),
    .port_id       (port_id),
    .out_port      (out_port),
    .write_strobe  (write_strobe),
    .read_strobe   (read_strobe),
    .interrupt_ack (interrupt_ack),
    .interrupt     (interrupt),
    .rd_data       (rd_data),
    .snap_busy     (snap_busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_reg(input string tag, input logic [7:0] port, input logic [7:0] exp);
    port_id = port;
    tick();
    check(tag, rd_data, exp);
  endtask

  task automatic write_ctl(input logic [7:0] data);
    port_id      = 8'h24;
    out_port     = data;
    write_strobe = 1'b1;
    tick();
    write_strobe = 1'b0;
  endtask

  task automatic pulse();
    upd_sysregs = 1'b1;
    tick();
    upd_sysregs = 1'b0;
    tick();
  endtask

  task automatic ack();
    interrupt_ack = 1'b1;
    tick();
    interrupt_ack = 1'b0;
  endtask

  initial begin
    rst = 1'b1; upd_sysregs = 1'b0;
    locx = 8'h00; locy = 8'h00; sensors = 8'h00; botinfo = 8'h00;
    port_id = 8'h00; out_port = 8'h00;
    write_strobe = 1'b0; read_strobe = 1'b0; interrupt_ack = 1'b0;
    tick(); tick();
    check("reset_irq", {7'b0, interrupt}, 8'h00);
    check("reset_busy", {7'b0, snap_busy}, 8'h00);
    check("reset_rd", rd_data, 8'h00);
    rst = 1'b0;
    check_reg("reset_status", 8'h24, 8'h01);

    // 1: single capture
    locx = 8'h3A; locy = 8'h51; sensors = 8'h07; botinfo = 8'h42;
    upd_sysregs = 1'b1;
    tick();
    check("t1_irq", {7'b0, interrupt}, 8'h01);
    check("t1_busy", {7'b0, snap_busy}, 8'h01);
    upd_sysregs = 1'b0;
    locx = 8'hEE;
    check_reg("t1_locx", 8'h20, 8'h3A);
    check_reg("t1_locy", 8'h21, 8'h51);
    check_reg("t1_sens", 8'h22, 8'h07);
    check_reg("t1_info", 8'h23, 8'h42);
    check_reg("t1_status", 8'h24, 8'h03);
    check_reg("t1_off7", 8'h27, 8'h00);
    check_reg("t1_above_win", 8'h28, 8'h00);
    check_reg("t1_below_win", 8'h1F, 8'h00);

    // 2: ack, overruns in SERV, release
    ack();
    check("t2_irq_after_ack", {7'b0, interrupt}, 8'h00);
    check_reg("t2_status_serv", 8'h24, 8'h05);
    for (int i = 0; i < 3; i++) begin
      locx = 8'h90 + 8'(i); locy = 8'hA0; sensors = 8'hB0; botinfo = 8'hC0;
      pulse();
    end
    check_reg("t2_locx_frozen", 8'h20, 8'h3A);
    check_reg("t2_info_frozen", 8'h23, 8'h42);
    check_reg("t2_ovr", 8'h25, 8'h03);
    write_ctl(8'h03);
    check_reg("t2_status_idle", 8'h24, 8'h01);

    // 3: ack timeout
    locx = 8'h11; locy = 8'h12; sensors = 8'h13; botinfo = 8'h14;
    upd_sysregs = 1'b1;
    tick();
    upd_sysregs = 1'b0;
    for (int i = 1; i < 1000; i++) tick();
    check("t3_irq_before_expiry", {7'b0, interrupt}, 8'h01);
    tick();
    check("t3_irq_after_expiry", {7'b0, interrupt}, 8'h00);
    check_reg("t3_tocnt", 8'h26, 8'h01);
    check_reg("t3_status", 8'h24, 8'h01);
    check_reg("t3_ovr_kept", 8'h25, 8'h03);
    locx = 8'h22;
    pulse();
    check("t3_recapture_irq", {7'b0, interrupt}, 8'h01);
    check_reg("t3_recapture_locx", 8'h20, 8'h22);
    ack();

    // 4: overrun saturation, clear beats simultaneous increment
    for (int i = 0; i < 300; i++) pulse();
    check_reg("t4_ovr_sat", 8'h25, 8'hFF);
    port_id = 8'h24; out_port = 8'h06; write_strobe = 1'b1; upd_sysregs = 1'b1;
    tick();
    write_strobe = 1'b0; upd_sysregs = 1'b0;
    tick();
    check_reg("t4_ovr_cleared", 8'h25, 8'h00);
    check_reg("t4_to_cleared", 8'h26, 8'h00);
    check_reg("t4_status_serv", 8'h24, 8'h05);
    write_ctl(8'h03);
    check_reg("t4_status_idle", 8'h24, 8'h01);

    // 5: disabled events ignored, held level captures once
    write_ctl(8'h00);
    check_reg("t5_status_dis", 8'h24, 8'h00);
    locx = 8'h77;
    pulse();
    check("t5_no_irq", {7'b0, interrupt}, 8'h00);
    check_reg("t5_ovr", 8'h25, 8'h00);
    check_reg("t5_to", 8'h26, 8'h00);
    check_reg("t5_locx_kept", 8'h20, 8'h22);
    write_ctl(8'h02);
    check_reg("t5_status_en", 8'h24, 8'h01);
    locx = 8'h5A;
    upd_sysregs = 1'b1;
    tick();
    check("t5_hold_irq", {7'b0, interrupt}, 8'h01);
    locx = 8'h5B;
    for (int i = 1; i < 10; i++) tick();
    upd_sysregs = 1'b0;
    check_reg("t5_hold_ovr", 8'h25, 8'h00);
    check_reg("t5_hold_locx", 8'h20, 8'h5A);
    check_reg("t5_hold_status", 8'h24, 8'h03);

    // 6: asynchronous reset while in PEND
    #2;
    rst = 1'b1;
    #1;
    check("t6_async_irq", {7'b0, interrupt}, 8'h00);
    check("t6_async_busy", {7'b0, snap_busy}, 8'h00);
    tick(); tick();
    rst = 1'b0;
    check_reg("t6_locx", 8'h20, 8'h00);
    check_reg("t6_locy", 8'h21, 8'h00);
    check_reg("t6_sens", 8'h22, 8'h00);
    check_reg("t6_info", 8'h23, 8'h00);
    check_reg("t6_status", 8'h24, 8'h01);
    check_reg("t6_ovr", 8'h25, 8'h00);
    check_reg("t6_to", 8'h26, 8'h00);
    check_reg("t6_off7", 8'h27, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/bot_event_snap.md
Name: bot_event_snap

Overview:
- Sits between the RojoBot model and the KCPSM6 I/O path, feeding the interrupt and in_port read path.
- On each RojoBot register-update event it captures a coherent snapshot of LocX/LocY/Sensors/BotInfo and raises the CPU interrupt.
- It holds the snapshot until firmware releases it, and counts update events that were dropped while busy (overruns) and interrupts that were never acknowledged (timeouts).

Parameters:
PORT_BASE, 8'h20, base port_id of the 8-entry register window
ACK_TIMEOUT, 1000, cycles PEND waits for interrupt_ack before abandoning
EN_RESET, 1'b1, reset value of the enable control bit

Ports:
clk  in  1  system clock, 100 MHz
rst  in  1  asynchronous, active-high reset
upd_sysregs  in  1  RojoBot update flag; rising edge = one event
locx  in  8  RojoBot X location
locy  in  8  RojoBot Y location
sensors  in  8  RojoBot sensor register
botinfo  in  8  RojoBot info register
port_id  in  8  KCPSM6 port address
out_port  in  8  KCPSM6 write data
write_strobe  in  1  KCPSM6 write strobe
read_strobe  in  1  KCPSM6 read strobe (informational; reads have no side effects)
interrupt_ack  in  1  KCPSM6 interrupt acknowledge
interrupt  out  1  interrupt request to KCPSM6
rd_data  out  8  registered read data for in_port mux
snap_busy  out  1  high in PEND or SERV

Behaviour:
- Reset: all outputs 0; snapshot and counters 0; enable=EN_RESET; state IDLE; edge-detect flop 0.
- Event: ev = upd_sysregs & ~upd_d, where upd_d is upd_sysregs registered. A level held high counts once.
- FSM states IDLE, PEND, SERV.
  - IDLE: if ev & enable, capture all four inputs into the snapshot in that cycle, set interrupt=1 next cycle, go to PEND. If ev & ~enable, ignore (no count).
  - PEND: interrupt=1. On interrupt_ack, interrupt=0 next cycle and go to SERV. If the timer reaches ACK_TIMEOUT-1 with no ack, interrupt=0, timeout_cnt+1, go to IDLE. The timer clears on PEND entry.
  - SERV: snapshot frozen. A release write goes to IDLE.
- Overrun: any ev while in PEND or SERV increments overrun_cnt. The event is not captured.
- Counters: overrun_cnt and timeout_cnt are 8 bits and saturate at 8'hFF (no wrap).
- Simultaneous release and ev in SERV: the release wins, the ev is captured as a new event (SERV->PEND via capture), and it is not counted as an overrun.
- Simultaneous ack and timeout expiry: the ack wins; no timeout is counted.
- Simultaneous clear-counters and increment: the clear wins; result 0.
- Disable (enable->0) while in PEND or SERV: the current transaction completes normally. Only new captures are blocked.
- Register window, offset = port_id - PORT_BASE, valid for 0..7:
  - Read 0 LocX snap, 1 LocY snap, 2 Sensors snap, 3 BotInfo snap.
  - Read 4 status = {5'b0, state[1:0] (IDLE=0, PEND=1, SERV=2), enable}.
  - Read 5 overrun_cnt, 6 timeout_cnt, 7 reads 8'h00.
  - Write 4 (write_strobe) control: bit0 release (effective in SERV only, otherwise ignored), bit1 enable, bit2 clear both counters.
  - Writes to other offsets are ignored.
- rd_data: registered every cycle from port_id with 1-cycle latency, independent of read_strobe. port_id outside the window gives 8'h00.
- Reset asserted mid-transaction: the FSM returns to IDLE asynchronously, interrupt drops immediately, and the snapshot clears.

Decomposition:
- Shared package: state encodings (ST_IDLE/ST_PEND/ST_SERV), register offsets (OFF_LOCX..OFF_TOCNT), and control bit positions (CTL_RELEASE=0, CTL_ENABLE=1, CTL_CLRCNT=2).
- One natural sub-module: sat_counter8 (increment, clear, saturate at FF), instantiated for overrun_cnt and timeout_cnt.

Test Plan:
1. Reset then a single upd pulse with locx=8'h3A, locy=8'h51, sensors=8'h07, botinfo=8'h42 -> interrupt high 1 cycle after the edge. Reads of offsets 0-3 return 3A, 51, 07, 42; status reads 8'h03.
2. Ack, then 3 upd pulses while in SERV with inputs changing -> snapshot unchanged and overrun_cnt=3. Write 8'h03 to offset 4 -> status 8'h01 (IDLE, enabled).
3. upd pulse with no ack for ACK_TIMEOUT cycles -> interrupt falls at cycle ACK_TIMEOUT, timeout_cnt=1, state IDLE. The next upd re-captures normally.
4. 300 overruns -> overrun_cnt reads 8'hFF. Write 8'h06 (clear + enable) in the same cycle as an event -> count 0.
5. Write 8'h00 (disable), then upd pulse -> no interrupt, counters unchanged. Hold upd_sysregs high 10 cycles after re-enable -> exactly one capture.
6. Assert rst while in PEND -> interrupt 0 asynchronously, all reads 8'h00 except status = 8'h01 (EN_RESET=1).
